// File: rtl/pwr_gate_ctrl.sv
// Power-gating sequencer for one switchable domain.
// Steps isolation, retention save, header ramp and restore in a fixed order.
module pwr_gate_ctrl #(
  parameter int unsigned RAMP_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  output logic       sw_en_n,
  output logic       iso_en,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       pwr_ok,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_ON      = 3'd0,
    S_ISO     = 3'd1,
    S_SAVE    = 3'd2,
    S_PGOFF   = 3'd3,
    S_OFF     = 3'd4,
    S_PGON    = 3'd5,
    S_RESTORE = 3'd6,
    S_DEISO   = 3'd7
  } st_t;

  localparam logic [3:0] LOAD = 4'(RAMP_CYC - 1);

  st_t        st;
  st_t        nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       armed;
  logic       ramp;

  // {sw_en_n, iso_en, ret_save, ret_restore, pwr_ok, busy}
  function automatic logic [5:0] dec(st_t s);
    logic [5:0] o;
    o = 6'b000010;
    unique case (s)
      S_ON:      o = 6'b000010;
      S_ISO:     o = 6'b010001;
      S_SAVE:    o = 6'b011001;
      S_PGOFF:   o = 6'b110001;
      S_OFF:     o = 6'b110000;
      S_PGON:    o = 6'b010001;
      S_RESTORE: o = 6'b010101;
      S_DEISO:   o = 6'b010001;
    endcase
    return o;
  endfunction

  assign ramp = (st == S_PGOFF) || (st == S_PGON);

  always_comb begin
    nx     = st;
    cnt_nx = '0;
    unique case (st)
      S_ON: begin
        if (armed && sleep_req)
          nx = S_ISO;
      end
      S_ISO: nx = S_SAVE;
      S_SAVE: begin
        nx     = S_PGOFF;
        cnt_nx = LOAD;
      end
      S_PGOFF: begin
        if (cnt > LOAD)
          nx = S_ON;
        else if (cnt == 4'd0)
          nx = S_OFF;
        else
          cnt_nx = cnt - 4'd1;
      end
      S_OFF: begin
        if (wake_req) begin
          nx     = S_PGON;
          cnt_nx = LOAD;
        end
      end
      S_PGON: begin
        if (cnt > LOAD)
          nx = S_ON;
        else if (cnt == 4'd0)
          nx = S_RESTORE;
        else
          cnt_nx = cnt - 4'd1;
      end
      S_RESTORE: nx = S_DEISO;
      S_DEISO:   nx = S_ON;
    endcase
    // a stray count outside the ramp states is a corrupted state
    if (!ramp && cnt != 4'd0) begin
      nx     = S_ON;
      cnt_nx = '0;
    end
  end

  // armed holds off the first transition for one edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_ON;
      cnt     <= '0;
      armed   <= 1'b0;
      sw_en_n <= 1'b0;
      iso_en  <= 1'b0;
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      pwr_ok  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      armed <= 1'b1;
      st    <= nx;
      cnt   <= cnt_nx;
      {sw_en_n, iso_en, ret_save,
       ret_restore, pwr_ok, busy} <= dec(nx);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_pwr_gate_ctrl.sv
// Directed bench for pwr_gate_ctrl.
// Runs RAMP_CYC=4, 1 and 15 side by side on one stimulus.
module tb_pwr_gate_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic sleep_req = 1'b0;
  logic wake_req = 1'b0;

  logic       sw_en_n[3];
  logic       iso_en[3];
  logic       ret_save[3];
  logic       ret_restore[3];
  logic       pwr_ok[3];
  logic       busy[3];
  logic [2:0] state[3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwr_gate_ctrl #(.RAMP_CYC(4)) u4 (
    .clk(clk), .rst(rst),
    .sleep_req(sleep_req), .wake_req(wake_req),
    .sw_en_n(sw_en_n[0]), .iso_en(iso_en[0]),
    .ret_save(ret_save[0]), .ret_restore(ret_restore[0]),
    .pwr_ok(pwr_ok[0]), .busy(busy[0]), .state(state[0])
  );

  pwr_gate_ctrl #(.RAMP_CYC(1)) u1 (
    .clk(clk), .rst(rst),
    .sleep_req(sleep_req), .wake_req(wake_req),
    .sw_en_n(sw_en_n[1]), .iso_en(iso_en[1]),
    .ret_save(ret_save[1]), .ret_restore(ret_restore[1]),
    .pwr_ok(pwr_ok[1]), .busy(busy[1]), .state(state[1])
  );

  pwr_gate_ctrl #(.RAMP_CYC(15)) u15 (
    .clk(clk), .rst(rst),
    .sleep_req(sleep_req), .wake_req(wake_req),
    .sw_en_n(sw_en_n[2]), .iso_en(iso_en[2]),
    .ret_save(ret_save[2]), .ret_restore(ret_restore[2]),
    .pwr_ok(pwr_ok[2]), .busy(busy[2]), .state(state[2])
  );

  // expected {sw_en_n, iso_en, ret_save, ret_restore, pwr_ok, busy}
  function automatic logic [5:0] exp_out(logic [2:0] s);
    logic [5:0] o;
    case (s)
      3'd0:    o = 6'b000010;
      3'd1:    o = 6'b010001;
      3'd2:    o = 6'b011001;
      3'd3:    o = 6'b110001;
      3'd4:    o = 6'b110000;
      3'd5:    o = 6'b010001;
      3'd6:    o = 6'b010101;
      default: o = 6'b010001;
    endcase
    return o;
  endfunction

  function automatic logic [8:0] obs(int i);
    return {state[i], sw_en_n[i], iso_en[i], ret_save[i],
            ret_restore[i], pwr_ok[i], busy[i]};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic chk_st(string tag, logic [2:0] s);
    chk(tag, 32'(obs(0)), 32'({s, exp_out(s)}));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] slp_seq[6];
  logic [2:0] wk_seq[6];
  int c3[3];
  int c5[3];

  initial begin
    slp_seq = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    wk_seq  = '{3'd5, 3'd5, 3'd5, 3'd6, 3'd7, 3'd0};
    c3 = '{0, 0, 0};
    c5 = '{0, 0, 0};

    rst = 1'b1;
    repeat (3) step();
    chk_st("rst_hold", 3'd0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk_st("idle", 3'd0);
    end

    // one-cycle sleep; wake pulses inside PGOFF must be ignored
    sleep_req = 1'b1;
    step();
    sleep_req = 1'b0;
    chk_st("slp_iso", 3'd1);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) wake_req = 1'b1;
      if (k == 4) wake_req = 1'b0;
      step();
      chk_st("slp_seq", slp_seq[k]);
    end

    sleep_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk_st("off_hold", 3'd4);
    end

    // both high in OFF: wake wins
    wake_req = 1'b1;
    step();
    wake_req  = 1'b0;
    sleep_req = 1'b0;
    chk_st("wk_pgon", 3'd5);
    for (int k = 0; k < 6; k++) begin
      step();
      chk_st("wk_seq", wk_seq[k]);
    end

    // both high in ON: sleep wins
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    step();
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    chk_st("both_on", 3'd1);
    step();
    chk_st("mid_save", 3'd2);
    step();
    chk_st("mid_pgoff", 3'd3);

    // asynchronous abort in PGOFF
    rst = 1'b1;
    #1;
    chk_st("arst", 3'd0);
    step();
    chk_st("arst_hold", 3'd0);

    // first edge after release must not transition
    sleep_req = 1'b1;
    rst = 1'b0;
    step();
    chk_st("rel_edge1", 3'd0);
    step();
    chk_st("rel_edge2", 3'd1);
    sleep_req = 1'b0;

    for (int k = 0; k < 40; k++) begin
      step();
      for (int i = 0; i < 3; i++)
        if (state[i] == 3'd3) c3[i]++;
    end
    chk("pgoff_len_r4", 32'(c3[0]), 32'd4);
    chk("pgoff_len_r1", 32'(c3[1]), 32'd1);
    chk("pgoff_len_r15", 32'(c3[2]), 32'd15);
    chk("off_r1", 32'(obs(1)), 32'({3'd4, exp_out(3'd4)}));
    chk("off_r15", 32'(obs(2)), 32'({3'd4, exp_out(3'd4)}));

    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    for (int i = 0; i < 3; i++)
      if (state[i] == 3'd5) c5[i]++;
    for (int k = 0; k < 40; k++) begin
      step();
      for (int i = 0; i < 3; i++)
        if (state[i] == 3'd5) c5[i]++;
    end
    chk("pgon_len_r4", 32'(c5[0]), 32'd4);
    chk("pgon_len_r1", 32'(c5[1]), 32'd1);
    chk("pgon_len_r15", 32'(c5[2]), 32'd15);
    chk_st("on_r4", 3'd0);
    chk("on_r1", 32'(obs(1)), 32'({3'd0, exp_out(3'd0)}));
    chk("on_r15", 32'(obs(2)), 32'({3'd0, exp_out(3'd0)}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
